// File: rtl/fsm_seq_ctrl.sv
// Table-driven 8-state FSM with a programmable 32x6 transition/output table
// and a symbol program that the controller plays into the FSM one step per clock.
module fsm_seq_ctrl #(
    parameter int DEPTH = 16,
    parameter int PW    = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cfg_we,
    input  logic [4:0]    cfg_addr,
    input  logic [5:0]    cfg_data,
    input  logic          prog_we,
    input  logic [PW-1:0] prog_addr,
    input  logic [1:0]    prog_sym,
    input  logic [PW:0]   prog_len,
    input  logic          start,
    input  logic          abort,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [1:0]    sym_out,
    output logic          sym_valid,
    output logic [2:0]    state,
    output logic [2:0]    saida,
    output logic [PW:0]   step_cnt
);

    typedef enum logic [1:0] {
        CTRL_IDLE = 2'd0,
        CTRL_RUN  = 2'd1,
        CTRL_DONE = 2'd2
    } ctrl_t;

    ctrl_t         ctrl_r, ctrl_s;
    logic [5:0]    tbl_r  [32];
    logic [1:0]    prog_r [DEPTH];
    logic [PW-1:0] ptr_r, ptr_s;
    logic [PW:0]   len_r, len_s;
    logic [PW:0]   step_r, step_s;
    logic [2:0]    state_r, state_s;
    logic [2:0]    saida_r, saida_s;
    logic          err_r, err_s;
    logic          tbl_wr_s, prog_wr_s;
    logic          len_ok_s;
    logic [1:0]    sym_s;
    logic [5:0]    entry_s;

    assign sym_s    = prog_r[ptr_r];
    assign entry_s  = tbl_r[{state_r, sym_s}];
    assign len_ok_s = (prog_len >= (PW+1)'(1)) && (prog_len <= (PW+1)'(DEPTH));

    // Controller next-state, datapath updates and rejection detection
    always_comb begin
        ctrl_s    = ctrl_r;
        ptr_s     = ptr_r;
        len_s     = len_r;
        step_s    = step_r;
        state_s   = state_r;
        saida_s   = saida_r;
        err_s     = 1'b0;
        tbl_wr_s  = 1'b0;
        prog_wr_s = 1'b0;
        case (ctrl_r)
            CTRL_IDLE: begin
                tbl_wr_s  = cfg_we;
                prog_wr_s = prog_we;
                if (start) begin
                    if (len_ok_s) begin
                        ctrl_s  = CTRL_RUN;
                        len_s   = prog_len;
                        ptr_s   = {PW{1'b0}};
                        step_s  = {(PW+1){1'b0}};
                        state_s = 3'd0;
                        saida_s = 3'd0;
                    end else begin
                        err_s = 1'b1;
                    end
                end else begin
                    ctrl_s = CTRL_IDLE;
                end
            end
            CTRL_RUN: begin
                if (cfg_we || prog_we) begin
                    err_s = 1'b1;
                end else begin
                    err_s = 1'b0;
                end
                // An abort takes precedence over the step scheduled for this edge
                if (abort) begin
                    ctrl_s = CTRL_IDLE;
                end else begin
                    state_s = entry_s[5:3];
                    saida_s = entry_s[2:0];
                    ptr_s   = ptr_r + PW'(1);
                    step_s  = step_r + (PW+1)'(1);
                    if ({1'b0, ptr_r} == (len_r - (PW+1)'(1))) begin
                        ctrl_s = CTRL_DONE;
                    end else begin
                        ctrl_s = CTRL_RUN;
                    end
                end
            end
            CTRL_DONE: begin
                ctrl_s = CTRL_IDLE;
                if (cfg_we || prog_we) begin
                    err_s = 1'b1;
                end else begin
                    err_s = 1'b0;
                end
            end
            default: begin
                ctrl_s = CTRL_IDLE;
            end
        endcase
    end

    // State, datapath and storage registers; reset clears table and program too
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_r  <= CTRL_IDLE;
            ptr_r   <= {PW{1'b0}};
            len_r   <= {(PW+1){1'b0}};
            step_r  <= {(PW+1){1'b0}};
            state_r <= 3'd0;
            saida_r <= 3'd0;
            err_r   <= 1'b0;
            for (int i = 0; i < 32; i++) begin
                tbl_r[i] <= 6'd0;
            end
            for (int i = 0; i < DEPTH; i++) begin
                prog_r[i] <= 2'd0;
            end
        end else begin
            ctrl_r  <= ctrl_s;
            ptr_r   <= ptr_s;
            len_r   <= len_s;
            step_r  <= step_s;
            state_r <= state_s;
            saida_r <= saida_s;
            err_r   <= err_s;
            if (tbl_wr_s) begin
                tbl_r[cfg_addr] <= cfg_data;
            end
            if (prog_wr_s) begin
                prog_r[prog_addr] <= prog_sym;
            end
        end
    end

    assign busy      = (ctrl_r == CTRL_RUN);
    assign done      = (ctrl_r == CTRL_DONE);
    assign err       = err_r;
    assign sym_valid = (ctrl_r == CTRL_RUN);
    assign sym_out   = (ctrl_r == CTRL_RUN) ? sym_s : 2'b00;
    assign state     = state_r;
    assign saida     = saida_r;
    assign step_cnt  = step_r;

endmodule

// File: tb/tb_fsm_seq_ctrl.sv
// Bench for fsm_seq_ctrl: directed scenarios plus random tables/programs,
// checked against an array-based model of the table walk.
module tb_fsm_seq_ctrl;
    localparam int DEPTH = 16;
    localparam int PW    = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          cfg_we;
    logic [4:0]    cfg_addr;
    logic [5:0]    cfg_data;
    logic          prog_we;
    logic [PW-1:0] prog_addr;
    logic [1:0]    prog_sym;
    logic [PW:0]   prog_len;
    logic          start;
    logic          abort;
    logic          busy, done, err, sym_valid;
    logic [1:0]    sym_out;
    logic [2:0]    state, saida;
    logic [PW:0]   step_cnt;

    logic [5:0] tbl_m  [32];
    logic [1:0] prog_m [DEPTH];
    int n_pass  = 0;
    int n_total = 0;

    fsm_seq_ctrl #(.DEPTH(DEPTH), .PW(PW)) dut (
        .clk(clk), .reset(reset),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_sym(prog_sym),
        .prog_len(prog_len), .start(start), .abort(abort),
        .busy(busy), .done(done), .err(err),
        .sym_out(sym_out), .sym_valid(sym_valid),
        .state(state), .saida(saida), .step_cnt(step_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 32; i++) tbl_m[i] = 6'd0;
        for (int i = 0; i < DEPTH; i++) prog_m[i] = 2'd0;
    endtask

    task automatic wr_tbl(input logic [4:0] a, input logic [5:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
        tick();
        cfg_we = 1'b0;
        tbl_m[a] = d;
    endtask

    task automatic wr_prog(input logic [PW-1:0] a, input logic [1:0] s);
        prog_we = 1'b1; prog_addr = a; prog_sym = s;
        tick();
        prog_we = 1'b0;
        prog_m[a] = s;
    endtask

    // Start a run of len symbols; optionally abort in RUN cycle abort_at or
    // attempt a rejected table write (table[2]=63) in RUN cycle wr_at.
    task automatic run_seq(input int len, input int abort_at, input int wr_at);
        logic [2:0] st;
        logic [2:0] sa;
        logic [5:0] e;
        int cnt;
        st = 3'd0; sa = 3'd0; cnt = 0;
        prog_len = (PW+1)'(len);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("run_busy", 32'(busy), 32'd1);
        chk("run_cnt0", 32'(step_cnt), 32'd0);
        chk("run_state0", 32'(state), 32'd0);
        for (int i = 0; i < len; i++) begin
            chk("sym_valid", 32'(sym_valid), 32'd1);
            chk("sym_out", 32'(sym_out), 32'(prog_m[i]));
            if (i == abort_at) abort = 1'b1;
            if (i == wr_at) begin
                cfg_we = 1'b1; cfg_addr = 5'd2; cfg_data = 6'b111111;
            end
            if (i == 1) start = 1'b1;
            tick();
            abort = 1'b0; cfg_we = 1'b0; start = 1'b0;
            chk("err", 32'(err), (i == wr_at) ? 32'd1 : 32'd0);
            if (i == abort_at) begin
                chk("abort_busy", 32'(busy), 32'd0);
                chk("abort_done", 32'(done), 32'd0);
                chk("abort_state", 32'(state), 32'(st));
                chk("abort_saida", 32'(saida), 32'(sa));
                chk("abort_cnt", 32'(step_cnt), 32'(cnt));
                tick();
                chk("abort_no_done", 32'(done), 32'd0);
                return;
            end
            e = tbl_m[{st, prog_m[i]}];
            st = e[5:3]; sa = e[2:0]; cnt++;
            chk("state", 32'(state), 32'(st));
            chk("saida", 32'(saida), 32'(sa));
            chk("step_cnt", 32'(step_cnt), 32'(cnt));
            if (i == len - 1) begin
                chk("done_pulse", 32'(done), 32'd1);
                chk("done_busy", 32'(busy), 32'd0);
                chk("done_sym_valid", 32'(sym_valid), 32'd0);
                tick();
                chk("done_clear", 32'(done), 32'd0);
                chk("idle_busy", 32'(busy), 32'd0);
            end else begin
                chk("mid_busy", 32'(busy), 32'd1);
                chk("mid_done", 32'(done), 32'd0);
            end
        end
    endtask

    task automatic bad_start(input logic [PW:0] len, input logic [2:0] st);
        prog_len = len;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("bad_err", 32'(err), 32'd1);
        chk("bad_busy", 32'(busy), 32'd0);
        chk("bad_state", 32'(state), 32'(st));
        tick();
        chk("bad_err_clear", 32'(err), 32'd0);
        chk("bad_busy2", 32'(busy), 32'd0);
    endtask

    initial begin
        int len;
        int ab;
        reset = 1'b0; cfg_we = 1'b0; cfg_addr = 5'd0; cfg_data = 6'd0;
        prog_we = 1'b0; prog_addr = {PW{1'b0}}; prog_sym = 2'd0;
        prog_len = {(PW+1){1'b0}}; start = 1'b0; abort = 1'b0;
        clear_model();
        #2;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_sym_valid", 32'(sym_valid), 32'd0);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_saida", 32'(saida), 32'd0);
        chk("rst_cnt", 32'(step_cnt), 32'd0);
        tick();
        reset = 1'b1;
        tick();

        // Directed three-step walk 0->1->2->0
        wr_tbl(5'd2, 6'b001000);
        wr_tbl(5'd6, 6'b010001);
        wr_tbl(5'd8, 6'b000010);
        wr_prog(4'd0, 2'b10);
        wr_prog(4'd1, 2'b10);
        wr_prog(4'd2, 2'b00);
        run_seq(3, -1, -1);

        run_seq(3, 2, -1);
        bad_start(5'd0, 3'd2);
        bad_start(5'd17, 3'd2);

        run_seq(3, -1, 1);
        run_seq(3, -1, -1);

        // Reset in the second RUN cycle
        prog_len = 5'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        reset = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_state", 32'(state), 32'd0);
        chk("midrst_saida", 32'(saida), 32'd0);
        chk("midrst_cnt", 32'(step_cnt), 32'd0);
        chk("midrst_sym_valid", 32'(sym_valid), 32'd0);
        clear_model();
        @(negedge clk);
        reset = 1'b1;
        tick();
        run_seq(3, -1, -1);

        // Random tables, programs, lengths and aborts
        for (int it = 0; it < 6; it++) begin
            for (int a = 0; a < 32; a++) wr_tbl(5'(a), 6'($urandom));
            for (int s = 0; s < DEPTH; s++) wr_prog(PW'(s), 2'($urandom));
            len = int'($urandom_range(1, DEPTH));
            ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, len - 1)) : -1;
            run_seq(len, ab, -1);
        end
        run_seq(DEPTH, -1, -1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/fsm_seq_ctrl.md
Name: fsm_seq_ctrl

Overview:
- Programmable controller for the team's table-driven 8-state FSM: a 32x6 transition/output ROM addressed by {state[2:0], a[1:0]}.
- Each entry is {next_state[2:0], out[2:0]}.
- The block owns the table, which is configured through a write port. It also holds a 16-entry program of 2-bit input symbols.
- It sequences the program into the FSM one symbol per clock and reports state, output, progress and completion. It replaces hand-written stimulus blocks for bring-up of FSM variants.

Parameters:
DEPTH, 16, maximum program length in symbols (power of 2)
PW, 4, program address width, log2(DEPTH)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
cfg_we  in  1  table write enable
cfg_addr  in  5  table address {state, a}
cfg_data  in  6  table entry {next_state, out}
prog_we  in  1  program write enable
prog_addr  in  PW  program slot
prog_sym  in  2  symbol written to slot
prog_len  in  PW+1  number of symbols to run, valid 1..DEPTH, sampled with start
start  in  1  run request, level sampled on clk
abort  in  1  stop request
busy  out  1  high in RUN
done  out  1  one-cycle pulse after last step
err  out  1  one-cycle pulse on rejected request
sym_out  out  2  symbol applied this cycle (0 when not RUN)
sym_valid  out  1  high in RUN
state  out  3  current FSM state
saida  out  3  registered out field of last taken entry
step_cnt  out  PW+1  steps taken in current/last run

Behaviour:
- Reset (async, reset=0), effective immediately:
  - table entries all 6'b000000; program slots all 2'b00
  - ctrl=IDLE; state=0, saida=0, step_cnt=0, ptr=0
  - busy=0, done=0, err=0, sym_valid=0
- Controller states: IDLE, RUN, DONE.
- IDLE:
  - cfg_we writes table[cfg_addr]<=cfg_data at the edge; prog_we writes prog[prog_addr]<=prog_sym at the edge.
  - Writes and start in the same cycle: writes complete first; run starts next edge.
  - start with 1<=prog_len<=DEPTH: latch len, ptr<=0, state<=0, saida<=0, step_cnt<=0, go RUN.
  - start with prog_len=0 or >DEPTH: stay IDLE, err=1 for one cycle.
- RUN, each cycle:
  - sym_out=prog[ptr] and sym_valid=1 (combinational from ptr).
  - At edge: e=table[{state,sym_out}]; state<=e[5:3]; saida<=e[2:0]; ptr<=ptr+1; step_cnt<=step_cnt+1.
  - When ptr==len-1 at the edge, take the step and go DONE.
  - Latency: start at edge N gives busy=1 after N. Steps occur on edges N+1..N+len. done is high for the cycle after edge N+len.
- DONE: done=1, busy=0, sym_valid=0. Next edge returns to IDLE unconditionally; start is ignored in DONE.
- abort in RUN: no step is taken that edge. Go IDLE with state, saida and step_cnt retained; done never pulses. abort outside RUN is ignored.
- cfg_we or prog_we while not IDLE: write dropped, err=1 for one cycle. start in RUN is ignored without err.
- err=1 whenever any rejection condition occurs in the cycle (OR of conditions).
- step_cnt maximum is DEPTH; no wrap. ptr wraps only via start.
- Table contents and program persist across runs; only reset clears them.
- Reset mid-run aborts the run, clears everything and returns to IDLE.

Test Plan:
1. Reset with no stimulus -> busy=0, done=0, err=0, sym_valid=0, state=0, saida=0, step_cnt=0.
2. Setup: write table[2]=6'b001000, table[6]=6'b010001, table[8]=6'b000010; program [10,10,00]; prog_len=3; pulse start.
   -> sym_out 10,10,00 on three RUN cycles; state 1,2,0; saida 0,1,2; done pulses once; step_cnt=3; busy 3 cycles.
3. start with prog_len=0, then prog_len=17 -> err pulses each time; busy stays 0; state unchanged.
4. Rerun scenario 2 with abort asserted in the 3rd RUN cycle -> state=2, saida=1, step_cnt=2, no done, IDLE next cycle.
5. cfg_we to table[2]=6'b111111 during RUN -> err pulse; the run and a subsequent rerun still give the sequence 1,2,0.
6. Assert reset during 2nd RUN cycle -> outputs zero at once; rerun of the same program (table cleared) -> state stays 0, saida 0, done after 3 steps.
